post_quant_unit: RTL
====================

# post_quant_unit

Requantization stage directly downstream of the systolic array. Consumes one row of `ArraySize` 32-bit accumulators per valid cycle, applies per-column bias, fixed-point multiply, rounding right shift, output offset and activation clamp, and emits packed int8 rows. A small output FIFO absorbs the array's back-to-back row bursts so the consumer may apply backpressure. The array itself cannot stall.

## Interface
- `ArraySize`, 4: columns per row.
- `AccWidth`, 32: accumulator lane width.
- `OutWidth`, 8: output lane width, signed.
- `FifoDepth`, 8: output FIFO entries. Power of two, at least `ArraySize`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_load` in 1: latches every `cfg_*` input at the edge; also clears `overflow`.
- `cfg_bias` in `ArraySize*AccWidth`: per-column bias, column 0 in the MSBs.
- `cfg_mult` in 32: signed quantized multiplier.
- `cfg_shift` in 5: right shift, 0..31.
- `cfg_out_offset` in 32: signed output zero-point.
- `cfg_act_min`, `cfg_act_max` in 8 each: signed clamp bounds.
- `in_valid`, `in_last` in 1 each: row strobe and last row of a tile.
- `in_row` in `ArraySize*AccWidth`: accumulator row, column 0 in the MSBs.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_last` out 1: last row of a tile.
- `out_row` out `ArraySize*OutWidth`: packed int8 results, column 0 in the MSBs.
- `overflow` out 1: sticky flag, set when a row was dropped.

## Operation
- The pipeline never stalls. `in_valid` is accepted every cycle, unconditionally.
- Per lane `j`, all arithmetic is signed:
  - S1: `a = in[j] + bias[j]`, 32-bit wrap.
  - S2: `p = a * mult`, full 64-bit product.
  - S3, SRDHM: if `a == mult == INT32_MIN`, the result is `INT32_MAX`. Otherwise `h = (p + nudge) / 2^31`, truncating toward zero, where `nudge = 2^30` if `p >= 0`, else `1 - 2^30`.
  - S3, RDBPOT: `mask = 2^shift - 1`; `rem = h & mask`; `thr = (mask >> 1) + (h < 0)`; `r = (h >>> shift) + (rem > thr)`.
  - S4: `o = clamp(r + out_offset, act_min, act_max)`, computed in 33 bits without wrap. The low 8 bits are written to the FIFO.
- `in_last` travels with its row through every stage and the FIFO.
- Config registers are used by every row in flight. Software asserts `cfg_load` only while the pipeline and FIFO are empty; a load while a row is in flight is undefined.
- Reset values of the config registers:
  - bias 0, mult 0, shift 0, offset 0.
  - `act_min` -128, `act_max` 127.
- FIFO write happens when S4 is valid.
  - If the FIFO is full and no pop occurs in the same cycle, the row is dropped and `overflow` is set.
  - A simultaneous push and pop while full is legal: the count is unchanged and no drop occurs.
- Pop happens when `out_valid & out_ready`.
- `out_valid`, `out_row` and `out_last` come from the FIFO head and stay stable until popped.

## Timing
- A row accepted at edge `t` is written to the FIFO at edge `t+4`. With the FIFO empty and `out_ready` high, `out_valid` is high in the cycle after edge `t+4` (4-cycle latency).
- Sustained throughput is 1 row/cycle when `out_ready` is held high.
- Reset, including mid-operation: at the next edge all pipeline valids and the FIFO count clear, and config returns to defaults.
- Output reset values: `out_valid` = 0, `out_last` = 0, `out_row` = 0, `overflow` = 0.
- `cfg_load` coincident with `rst`: reset wins.

## Structure
- Shared package `pq_pkg`:
  - `INT32_MIN`/`INT32_MAX` constants.
  - Default clamp constants.
  - `srdhm` and `rdbpot` functions, reused by the reference model.
- Sub-module `sync_fifo`: parameterized width/depth, registered head, full/empty, and legal push+pop when full.
- Per-lane datapath is a generate loop inside the top module.

## Test plan
- Identity path: load mult = 2^30, shift 0, bias 0, offset 0; input row {2, -2, 100, 300}. Expect out_row {1, -1, 50, 127}, with `out_valid` in the cycle after edge `t+4`.
- SRDHM edge case: bias 0, mult = `INT32_MIN`, input {`INT32_MIN`, 0, 1, -1}, shift 0, clamp ±128/127. Expect {127, 0, -1, 1}.
- Rounding: mult = 2^30, shift 1; inputs {6, -6, 10, -10}, giving `h` = {3, -3, 5, -5}. Expect {2, -2, 3, -3}.
- Bias, offset and clamp: bias {10, 0, 0, 0}, offset -128, mult 2^30, input {0, 0, 512, -4}. Expect {-123, -128, 127, -128}.
- Backpressure: push 10 rows with `out_ready` low (FifoDepth 8). Expect `overflow` = 1 and exactly the first 8 rows delivered in order, with `out_last` on the right row. Push+pop while full must drop nothing.
- Mid-stream reset: assert `rst` for 1 cycle with 3 rows in flight. Expect `out_valid` = 0 the next cycle, no stale row emitted, and config back to defaults.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared constants and fixed-point helpers for the post-quantization stage.
// Combinational helpers only; no latency of their own.
// No flow control; callers own sequencing.
package pq_pkg;

  localparam logic signed [31:0] INT32_MIN       = 32'sh8000_0000;
  localparam logic signed [31:0] INT32_MAX       = 32'sh7fff_ffff;
  localparam logic signed [7:0]  ACT_MIN_DEFAULT = 8'sh80;
  localparam logic signed [7:0]  ACT_MAX_DEFAULT = 8'sh7f;

  // Rounding nudges: +2^30 for non-negative products, 1-2^30 for negative ones.
  localparam logic signed [63:0] NUDGE_POS  = 64'sh0000_0000_4000_0000;
  localparam logic signed [63:0] NUDGE_NEG  = 64'shffff_ffff_c000_0001;
  // Added before an arithmetic shift so negative values truncate toward zero.
  localparam logic signed [63:0] TRUNC_BIAS = 64'sh0000_0000_7fff_ffff;

  // High half of a doubled, rounded product; 'sat' flags the MIN*MIN corner.
  function automatic logic signed [31:0] srdhm_prod(input logic signed [63:0] p,
                                                    input logic sat);
    logic signed [63:0] s;
    logic signed [63:0] t;
    s = p + (p[63] ? NUDGE_NEG : NUDGE_POS);
    t = s[63] ? (s + TRUNC_BIAS) : s;
    return sat ? INT32_MAX : 32'(t >>> 31);
  endfunction

  // Saturating rounding doubling high multiply of two int32 values.
  function automatic logic signed [31:0] srdhm(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
    logic signed [63:0] ae;
    logic signed [63:0] be;
    ae = {{32{a[31]}}, a};
    be = {{32{b[31]}}, b};
    return srdhm_prod(ae * be, (a == INT32_MIN) && (b == INT32_MIN));
  endfunction

  // Rounding divide by a power of two, ties away from zero.
  function automatic logic signed [31:0] rdbpot(input logic signed [31:0] h,
                                                input logic [4:0] shift);
    logic [31:0] mask;
    logic [31:0] rem;
    logic [31:0] thr;
    mask = (32'd1 << shift) - 32'd1;
    rem  = h & mask;
    thr  = (mask >> 1) + {31'd0, h[31]};
    return (h >>> shift) + ((rem > thr) ? 32'sd1 : 32'sd0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with storage-backed head and full/empty flags.
// Latency: a write is visible at the head the cycle after the write edge.
// A write while full is dropped (drop pulses) unless a read happens in the same cycle.
module sync_fifo #(
  parameter int Width = 33,
  parameter int Depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  output logic [Width-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign rd_ok   = rd_en & ~empty;
  // A read in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_ok   = wr_en & (~full | rd_ok);
  assign drop    = wr_en & full & ~rd_ok;
  assign rd_data = mem[rd_ptr];

  // Pointer, occupancy and storage update; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PtrW'(1);
      end
      if (rd_ok) rd_ptr <= rd_ptr + PtrW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/post_quant_unit.sv
// Requantizes accumulator rows to packed int8 rows (bias, multiply, shift, offset, clamp).
// Latency: 4 cycles to FIFO write; out_valid the cycle after (empty FIFO).
// Input never stalls; output FIFO absorbs backpressure, overflowing rows are dropped and flagged.
module post_quant_unit import pq_pkg::*; #(
  parameter int ArraySize = 4,
  parameter int AccWidth  = 32,
  parameter int OutWidth  = 8,
  parameter int FifoDepth = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_load,
  input  logic [ArraySize*AccWidth-1:0] cfg_bias,
  input  logic [31:0]                   cfg_mult,
  input  logic [4:0]                    cfg_shift,
  input  logic [31:0]                   cfg_out_offset,
  input  logic [OutWidth-1:0]           cfg_act_min,
  input  logic [OutWidth-1:0]           cfg_act_max,
  input  logic                          in_valid,
  input  logic                          in_last,
  input  logic [ArraySize*AccWidth-1:0] in_row,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [ArraySize*OutWidth-1:0] out_row,
  output logic                          overflow
);

  // Configuration shared by every row in flight.
  logic [ArraySize*AccWidth-1:0] bias_q;
  logic signed [31:0]            mult_q;
  logic [4:0]                    shift_q;
  logic signed [31:0]            offset_q;
  logic signed [OutWidth-1:0]    act_min_q;
  logic signed [OutWidth-1:0]    act_max_q;

  // Stage valids and the tile-last marker travelling with each row.
  logic s1_vld, s2_vld, s3_vld, s4_vld;
  logic s1_last, s2_last, s3_last, s4_last;
  logic [ArraySize*OutWidth-1:0] s4_row;

  logic fifo_full, fifo_empty, fifo_drop, pop;

  // Config latch; reset takes priority over a coincident load.
  always_ff @(posedge clk) begin
    if (rst) begin
      bias_q    <= '0;
      mult_q    <= '0;
      shift_q   <= '0;
      offset_q  <= '0;
      act_min_q <= OutWidth'(ACT_MIN_DEFAULT);
      act_max_q <= OutWidth'(ACT_MAX_DEFAULT);
    end else if (cfg_load) begin
      bias_q    <= cfg_bias;
      mult_q    <= cfg_mult;
      shift_q   <= cfg_shift;
      offset_q  <= cfg_out_offset;
      act_min_q <= cfg_act_min;
      act_max_q <= cfg_act_max;
    end
  end

  // Row valid/last shift register alongside the lane datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      {s1_vld, s2_vld, s3_vld, s4_vld}     <= '0;
      {s1_last, s2_last, s3_last, s4_last} <= '0;
    end else begin
      s1_vld  <= in_valid;
      s2_vld  <= s1_vld;
      s3_vld  <= s2_vld;
      s4_vld  <= s3_vld;
      s1_last <= in_valid & in_last;
      s2_last <= s1_last;
      s3_last <= s2_last;
      s4_last <= s3_last;
    end
  end

  // Sticky drop flag, cleared by a config load.
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else     overflow <= (overflow & ~cfg_load) | fifo_drop;
  end

  for (genvar j = 0; j < ArraySize; j++) begin : g_lane
    localparam int AccHi = (ArraySize - j) * AccWidth - 1;
    localparam int OutHi = (ArraySize - j) * OutWidth - 1;

    logic signed [31:0]         acc;
    logic signed [31:0]         bias;
    logic signed [31:0]         a_q;
    logic signed [63:0]         a_ext;
    logic signed [63:0]         m_ext;
    logic signed [63:0]         p_q;
    logic                       sat_q;
    logic signed [31:0]         r_q;
    logic signed [32:0]         sum;
    logic signed [32:0]         lo;
    logic signed [32:0]         hi;
    logic [OutWidth-1:0]        clamped;
    logic [OutWidth-1:0]        o_q;

    assign acc   = in_row[AccHi -: AccWidth];
    assign bias  = bias_q[AccHi -: AccWidth];
    assign a_ext = {{32{a_q[31]}}, a_q};
    assign m_ext = {{32{mult_q[31]}}, mult_q};
    // Offset add is one bit wider so a large offset cannot wrap before the clamp.
    assign sum   = {r_q[31], r_q} + {offset_q[31], offset_q};
    assign lo    = {{(33 - OutWidth){act_min_q[OutWidth-1]}}, act_min_q};
    assign hi    = {{(33 - OutWidth){act_max_q[OutWidth-1]}}, act_max_q};
    assign clamped = (sum < lo) ? act_min_q :
                     (sum > hi) ? act_max_q : sum[OutWidth-1:0];

    // Lane pipeline: bias, product, rounded shift, offset+clamp; data only moves with a valid row.
    always_ff @(posedge clk) begin
      if (in_valid) a_q <= acc + bias;
      if (s1_vld) begin
        p_q   <= a_ext * m_ext;
        sat_q <= (a_q == INT32_MIN) && (mult_q == INT32_MIN);
      end
      if (s2_vld) r_q <= rdbpot(srdhm_prod(p_q, sat_q), shift_q);
      if (s3_vld) o_q <= clamped;
    end

    assign s4_row[OutHi -: OutWidth] = o_q;
  end

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  sync_fifo #(
    .Width (ArraySize*OutWidth + 1),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s4_vld),
    .wr_data ({s4_last, s4_row}),
    .rd_en   (pop),
    .rd_data ({out_last, out_row}),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .drop    (fifo_drop)
  );

endmodule
